// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_packer.sv
// DCT code packer for the OCI trace bench: 2-bit codes into 15-slot frames,
// valid/ready frame output, and end-of-test drain sequencing.
module soc_system_pcp_0_cpu_0_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       code_in,
  input  logic                    code_valid,
  input  logic                    flush,
  input  logic                    end_req,
  input  logic                    dct_ready,
  output logic [CODE_W*SLOTS-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    dct_valid,
  output logic                    overflow,
  output logic [7:0]              drop_cnt,
  output logic                    test_ending,
  output logic                    test_has_ended
);

  localparam int FW = CODE_W * SLOTS;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ENDED
  } state_t;

  state_t           state;
  logic [FW-1:0]    acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             live;
  logic             cv;
  logic             can_xfer;
  logic             full;
  logic             drop;
  logic             close;
  logic             xfer;
  logic             code_first;
  logic             done;
  logic [FW-1:0]    shifted;
  logic [FW-1:0]    merged;
  logic [CNT_W-1:0] merged_cnt;

  always_comb begin
    live       = (state != ENDED);
    cv         = code_valid & live;
    can_xfer   = !dct_valid | dct_ready;
    full       = (acc_cnt == CNT_W'(SLOTS));
    shifted    = FW'(code_in) << (CODE_W * int'(acc_cnt));
    merged     = full ? acc : (acc | (cv ? shifted : '0));
    merged_cnt = acc_cnt + CNT_W'(cv & !full);
    drop       = full & !can_xfer & cv;
    close      = full
               | (merged_cnt == CNT_W'(SLOTS))
               | (((flush & live) | flush_pend)
                  & (merged_cnt != '0))
               | ((state == DRAIN) & (acc_cnt != '0));
    xfer       = close & can_xfer;
    // a full frame leaves whole, so the new code opens the next one
    code_first = full & cv;
    done       = (state == DRAIN) & (acc_cnt == '0)
               & !cv & can_xfer;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      acc            <= '0;
      acc_cnt        <= '0;
      flush_pend     <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      overflow       <= 1'b0;
      drop_cnt       <= '0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (xfer) begin
        dct_buffer <= merged;
        dct_count  <= merged_cnt;
        dct_valid  <= 1'b1;
        acc        <= code_first ? FW'(code_in) : '0;
        acc_cnt    <= CNT_W'(code_first);
        flush_pend <= 1'b0;
      end else begin
        acc        <= merged;
        acc_cnt    <= merged_cnt;
        if (dct_ready)
          dct_valid <= 1'b0;
        if (flush & live & !full & (merged_cnt != '0))
          flush_pend <= 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        RUN: begin
          if (end_req) begin
            state       <= DRAIN;
            test_ending <= 1'b1;
          end
        end
        DRAIN: begin
          if (done) begin
            state          <= ENDED;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus randomized traffic
// checked every cycle against a queue-based frame model.
module tb_soc_system_pcp_0_cpu_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  code_in;
  logic        code_valid;
  logic        flush;
  logic        end_req;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        test_ending;
  logic        test_has_ended;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  soc_system_pcp_0_cpu_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .code_in        (code_in),
    .code_valid     (code_valid),
    .flush          (flush),
    .end_req        (end_req),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  // model: open frame as a queue of codes, one held frame, end-of-test phase
  int          acc_q[$];
  bit          m_hv;
  int          m_hcnt;
  logic [29:0] m_hbuf;
  bit          m_ovf;
  int          m_drops;
  int          m_st;
  bit          m_fp;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] pack(int q[$]);
    logic [29:0] r = '0;
    foreach (q[i]) r |= 30'(q[i]) << (2 * i);
    return r;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_hv = 0; m_hcnt = 0; m_hbuf = '0;
    m_ovf = 0; m_drops = 0; m_st = 0; m_fp = 0;
  endtask

  task automatic model_step(bit cv, int code, bit fl, bit er, bit rdy);
    int n = acc_q.size();
    bit live = (m_st != 2);
    bit c = cv && live;
    bit go = !m_hv || rdy;
    bit hv_old = m_hv;
    bit xf = 0;
    int frame[$];
    int m;
    if (n == 15) begin
      if (go) begin
        frame = acc_q; acc_q.delete();
        if (c) acc_q.push_back(code);
        xf = 1;
      end else if (c) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end else begin
      if (c) acc_q.push_back(code);
      m = acc_q.size();
      if (m > 0 && (m == 15 || (fl && live) || m_fp || (m_st == 1 && n > 0))) begin
        if (go) begin
          frame = acc_q; acc_q.delete(); xf = 1;
        end else if (fl && live) m_fp = 1;
      end
    end
    if (xf) begin
      m_fp = 0; m_hv = 1;
      m_hcnt = frame.size(); m_hbuf = pack(frame);
    end else if (rdy) m_hv = 0;
    if (m_st == 0 && er) m_st = 1;
    else if (m_st == 1 && n == 0 && !c && (!hv_old || rdy)) m_st = 2;
  endtask

  task automatic compare();
    chk("dct_valid", 32'(dct_valid), 32'(m_hv));
    if (m_hv) begin
      chk("dct_buffer", 32'(dct_buffer), 32'(m_hbuf));
      chk("dct_count", 32'(dct_count), 32'(m_hcnt));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    chk("test_ending", 32'(test_ending), 32'(m_st == 1));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_st == 2));
  endtask

  task automatic cyc(bit cv, int code, bit fl, bit er, bit rdy);
    code_valid = cv; code_in = 2'(code);
    flush = fl; end_req = er; dct_ready = rdy;
    @(posedge clk);
    model_step(cv, code, fl, er, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(int k, bit rdy);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, rdy);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_buf"}, 32'(dct_buffer), 0);
    chk({nm, "_cnt"}, 32'(dct_count), 0);
    chk({nm, "_valid"}, 32'(dct_valid), 0);
    chk({nm, "_ovf"}, 32'(overflow), 0);
    chk({nm, "_drops"}, 32'(drop_cnt), 0);
    chk({nm, "_ending"}, 32'(test_ending), 0);
    chk({nm, "_ended"}, 32'(test_has_ended), 0);
  endtask

  task automatic do_reset();
    reset = 1;
    code_valid = 0; code_in = 0; flush = 0; end_req = 0; dct_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit stall;
    int dens[4] = '{50, 90, 100, 20};
    reset = 1;
    code_valid = 0; code_in = 0; flush = 0; end_req = 0; dct_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 0;

    // 15 codes 0,1,2,3,... closes a full frame
    for (int i = 0; i < 15; i++) begin
      cyc(1, i % 4, 0, 0, 1);
      if (i == 13) chk("t1_not_early", 32'(dct_valid), 0);
    end
    chk("t1_valid", 32'(dct_valid), 1);
    chk("t1_cnt", 32'(dct_count), 15);
    chk("t1_buf", 32'(dct_buffer), 32'h24E4E4E4);
    chk("t1_model_buf", 32'(m_hbuf), 32'h24E4E4E4);
    idle(2, 1);

    // three codes then flush
    do_reset();
    cyc(1, 3, 0, 0, 1); cyc(1, 2, 0, 0, 1); cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("t2_cnt", 32'(dct_count), 3);
    chk("t2_buf", 32'(dct_buffer), 32'h1B);
    chk("t2_model_buf", 32'(m_hbuf), 32'h1B);
    idle(2, 1);

    // stalled consumer, 31 codes: last one is dropped
    do_reset();
    for (int i = 0; i < 31; i++) cyc(1, $urandom_range(0, 3), 0, 0, 0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drops", 32'(drop_cnt), 1);
    chk("t3_cnt1", 32'(dct_count), 15);
    cyc(0, 0, 0, 0, 1);
    chk("t3_second_valid", 32'(dct_valid), 1);
    chk("t3_cnt2", 32'(dct_count), 15);
    cyc(0, 0, 0, 0, 1);
    chk("t3_drained", 32'(dct_valid), 0);

    // code plus flush in one cycle; full frame handed off with new code
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1);
    cyc(1, 2, 1, 0, 1);
    chk("t4_cnt", 32'(dct_count), 5);
    chk("t4_slot4", 32'(dct_buffer[9:8]), 2);
    idle(1, 1);
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 3, 0, 0, 1);
    chk("t4_full_cnt", 32'(dct_count), 15);
    cyc(0, 0, 1, 0, 1);
    chk("t4_next_cnt", 32'(dct_count), 1);
    chk("t4_next_buf", 32'(dct_buffer), 3);
    idle(2, 1);

    // end of test with a 7-code partial frame
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, $urandom_range(0, 3), 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("t5_ending", 32'(test_ending), 1);
    cyc(0, 0, 0, 0, 0);
    chk("t5_cnt", 32'(dct_count), 7);
    chk("t5_valid", 32'(dct_valid), 1);
    cyc(0, 0, 0, 0, 0);
    chk("t5_still_ending", 32'(test_ending), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_ended", 32'(test_has_ended), 1);
    chk("t5_ending_low", 32'(test_ending), 0);
    for (int i = 0; i < 40; i++) cyc(1, $urandom_range(0, 3), i % 3 == 0, 1, i % 2);
    chk("t5_no_frames", 32'(dct_valid), 0);
    chk("t5_no_drops", 32'(drop_cnt), 0);

    // reset mid-frame discards everything
    do_reset();
    for (int i = 0; i < 24; i++) cyc(1, 2, 0, 0, 0);
    chk("t6_model_acc", 32'(acc_q.size()), 9);
    chk("t6_pre_valid", 32'(dct_valid), 1);
    reset = 1;
    #1;
    chk_zero("t6_async");
    model_reset();
    @(negedge clk);
    reset = 0;
    cyc(1, 1, 0, 0, 1); cyc(1, 3, 1, 0, 1);
    chk("t6_cnt", 32'(dct_count), 2);
    chk("t6_buf", 32'(dct_buffer), 32'hD);

    // drop counter saturates
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1, 0, 0, 0, 0);
    chk("sat_drops", 32'(drop_cnt), 255);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      stall = 0;
      for (int c = 0; c < 2500; c++) begin
        if ($urandom_range(0, 19) == 0) stall = !stall;
        cyc($urandom_range(0, 99) < dens[r],
            $urandom_range(0, 3),
            $urandom_range(0, 99) < 4,
            c >= 2300 && r != 3,
            stall ? $urandom_range(0, 9) == 0 : $urandom_range(0, 9) < 8);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
